ascon_init_ctrl: RTL and testbench
==================================

ASCON_INIT_CTRL -- requirements
Module: ascon_init_ctrl

Interface
REQ-001 The block SHALL have parameter IV, default 64'h80400c0600000000, Ascon-128 initialization vector loaded into word x0.
REQ-002 The block SHALL have parameter TIMEOUT, default 20, the maximum number of cycles in RUN before an error is flagged.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_valid_i  in  1  host request valid.
REQ-006 req_ready_o  out  1  controller can accept a request.
REQ-007 key_i  in  128  key K; bits [127:64] are K_hi and [63:0] are K_lo.
REQ-008 nonce_i  in  128  nonce N; bits [127:64] are N_hi and [63:0] are N_lo.
REQ-009 init_start_o  out  1  one-cycle start pulse to the init permutation engine.
REQ-010 init_state_o  out  5x64 (state_t)  initial state presented to the engine.
REQ-011 init_state_i  in  5x64 (state_t)  permuted state from the engine.
REQ-012 init_update_i  in  1  engine state-valid strobe, high during each round cycle.
REQ-013 init_finished_i  in  1  engine completion pulse.
REQ-014 rsp_valid_o  out  1  result valid.
REQ-015 rsp_ready_i  in  1  host accepts result.
REQ-016 rsp_state_o  out  5x64  initialized state.
REQ-017 rsp_err_o  out  1  engine timeout; rsp_state_o is invalid when set.
REQ-018 busy_o  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, START, RUN, FINAL, RESP.
REQ-020 In IDLE, req_ready_o SHALL be 1.
- On req_valid_i && req_ready_o: latch key_i and nonce_i.
- Build the state as x0=IV, x1=K_hi, x2=K_lo, x3=N_hi, x4=N_lo.
- Go to START.
REQ-021 In START:
- init_start_o=1 for exactly one cycle.
- init_state_o SHALL equal the built state.
- Clear the timeout counter, then go to RUN.
REQ-022 init_state_o SHALL hold the built state from START until leaving RUN, and SHALL be 0 otherwise.
REQ-023 In RUN, a capture register SHALL load init_state_i on every cycle with init_update_i=1; the last captured value is the permutation result.
REQ-024 In RUN, init_finished_i=1 SHALL cause a transition to FINAL on the next edge.
REQ-025 In RUN, the timeout counter SHALL increment each cycle; when it reaches TIMEOUT without init_finished_i, go to RESP with rsp_err_o=1.
REQ-026 If init_finished_i and the timeout occur in the same cycle, init_finished_i SHALL win (no error).
REQ-027 In FINAL (one cycle), the block SHALL compute rsp_state as:
- x0..x2 unchanged from capture.
- x3 = capture.x3 ^ K_hi.
- x4 = capture.x4 ^ K_lo.
- rsp_err=0; then go to RESP.
REQ-028 In RESP, rsp_valid_o=1 and rsp_state_o/rsp_err_o SHALL hold stable until rsp_ready_i=1; then return to IDLE.
REQ-029 Request-to-response latency SHALL be: 1 (accept) + 1 (START) + engine cycles + 1 (FINAL); for a 12-round engine, rsp_valid_o rises 15 cycles after the accept edge.
REQ-030 init_finished_i and init_update_i SHALL be ignored outside RUN.
REQ-031 req_valid_i SHALL be ignored outside IDLE; no request is queued.
REQ-032 The 0-clearing of rsp_state_o/rsp_err_o SHALL occur on exit from RESP, so that stale data is never visible outside RESP.

Reset
REQ-033 With rst_i=1 at an edge, the block SHALL go to IDLE with these reset values:
- req_ready_o=1 after reset release.
- rsp_valid_o=0, rsp_err_o=0, init_start_o=0, busy_o=0.
- rsp_state_o=0, init_state_o=0.
- Capture register and latched key/nonce = 0.
REQ-034 Reset in any state, including RUN, SHALL abort the operation without emitting a response; a subsequent stray init_finished_i SHALL be ignored.

Verification
REQ-035 Reset: assert rst_i 2 cycles -> all outputs at REQ-033 values; req_ready_o=1.
REQ-036 Nominal: key=0x000102..0f, nonce=0x101112..1f; engine model returns all-ones on the round-12 update and finishes after 12 cycles. Required response:
- init_state_o.x0=IV and x1=0x0001020304050607.
- rsp_valid_o rises 15 cycles after accept.
- rsp x0..x2 = all-ones; x3=~0x0001020304050607; x4=~0x08090a0b0c0d0e0f; rsp_err_o=0.
REQ-037 Backpressure: hold rsp_ready_i=0 for 10 cycles in RESP and toggle key_i/req_valid_i -> rsp_state_o is stable, req_ready_o=0, and no second start is issued.
REQ-038 Timeout: engine never finishes -> rsp_valid_o=1 with rsp_err_o=1 after TIMEOUT(20) RUN cycles; init_finished_i arriving on the same cycle as the timeout -> rsp_err_o=0.
REQ-039 Reset mid-RUN at round 5, then engine init_finished_i pulse -> no rsp_valid_o and FSM in IDLE; a new request then completes normally.
REQ-040 Back-to-back: two requests with rsp_ready_i tied 1 -> two starts, each exactly one cycle, and two correct responses in order.

Source files
------------

// File: rtl/ascon_init_ctrl_if.sv
// Host request/response and permutation-engine signals of the Ascon initialization controller.
// The slave modport is the controller; the master modport is its environment (host plus engine).
interface ascon_init_ctrl_if;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [127:0]     key_i;
  logic [127:0]     nonce_i;
  logic             init_start_o;
  logic [4:0][63:0] init_state_o;
  logic [4:0][63:0] init_state_i;
  logic             init_update_i;
  logic             init_finished_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [4:0][63:0] rsp_state_o;
  logic             rsp_err_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, key_i, nonce_i, init_state_i, init_update_i, init_finished_i, rsp_ready_i,
    output req_ready_o, init_start_o, init_state_o, rsp_valid_o, rsp_state_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, key_i, nonce_i, init_state_i, init_update_i, init_finished_i, rsp_ready_i,
    input  req_ready_o, init_start_o, init_state_o, rsp_valid_o, rsp_state_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/ascon_init_ctrl.sv
// Ascon-128 initialization sequencer: builds IV||K||N, drives the permutation engine,
// folds the key back into the permuted state and hands the result to the host.
module ascon_init_ctrl #(
  parameter logic [63:0] IV      = 64'h80400c0600000000,
  parameter int unsigned TIMEOUT = 20
) (
  input logic              clk_i,
  input logic              rst_i,
  ascon_init_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, FINAL, RESP} state_e;

  state_e           state_reg, state_next;
  logic [127:0]     key_reg, key_next;
  logic [127:0]     nonce_reg, nonce_next;
  logic [4:0][63:0] cap_reg, cap_next;
  logic [4:0][63:0] rsp_state_reg, rsp_state_next;
  logic             rsp_err_reg, rsp_err_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [4:0][63:0] built;
  logic [4:0][63:0] key_mix;
  logic [4:0][63:0] final_state;

  // Word [0] is x0; packing order puts N_lo in x4.
  assign built   = {nonce_reg[63:0], nonce_reg[127:64], key_reg[63:0], key_reg[127:64], IV};
  assign key_mix = {key_reg[63:0], key_reg[127:64], 192'd0};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_final
      assign final_state[gi] = cap_reg[gi] ^ key_mix[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      key_reg       <= '0;
      nonce_reg     <= '0;
      cap_reg       <= '0;
      rsp_state_reg <= '0;
      rsp_err_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      nonce_reg     <= nonce_next;
      cap_reg       <= cap_next;
      rsp_state_reg <= rsp_state_next;
      rsp_err_reg   <= rsp_err_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    nonce_next     = nonce_reg;
    cap_next       = cap_reg;
    rsp_state_next = rsp_state_reg;
    rsp_err_next   = rsp_err_reg;
    cnt_next       = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid_i) begin
          key_next   = bus.key_i;
          nonce_next = bus.nonce_i;
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        cap_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (bus.init_update_i) begin
          cap_next = bus.init_state_i;
        end
        cnt_next = cnt_reg + CW'(1);
        // A finish arriving on the timeout cycle still counts as success.
        if (bus.init_finished_i) begin
          state_next = FINAL;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rsp_state_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end
      end
      FINAL: begin
        rsp_state_next = final_state;
        rsp_err_next   = 1'b0;
        state_next     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_state_next = '0;
          rsp_err_next   = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready_o  = (state_reg == IDLE);
  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.init_start_o = (state_reg == START);
  assign bus.init_state_o = ((state_reg == START) || (state_reg == RUN)) ? built : '0;
  assign bus.rsp_valid_o  = (state_reg == RESP);
  assign bus.rsp_state_o  = rsp_state_reg;
  assign bus.rsp_err_o    = rsp_err_reg;
endmodule

// File: tb/tb_ascon_init_ctrl.sv
// Randomized bench for ascon_init_ctrl: a timeline model derived from the accept cycle,
// run length and response hold predicts every output on every cycle.
module tb_ascon_init_ctrl;
  localparam logic [63:0] IV      = 64'h80400c0600000000;
  localparam int          TIMEOUT = 20;
  localparam int          BIG     = 32'h3fffffff;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ascon_init_ctrl_if bus();

  ascon_init_ctrl #(.IV(IV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int txn_no   = 0;

  // Current transaction as seen by the model
  logic [127:0]     t_key   = '0;
  logic [127:0]     t_nonce = '0;
  logic [4:0][63:0] t_exp   = '0;
  int               t_R     = 0;
  bit               t_fin   = 1'b0;
  int               t_acc   = 0;
  int               t_end   = 0;

  // Observations used by the literal checks
  int               start_cnt  = 0;
  int               rise_cnt   = 0;
  int               last_rise  = 0;
  bit               prev_valid = 1'b0;
  logic [4:0][63:0] seen_rsp   = '0;
  logic             seen_err   = 1'b0;
  logic [4:0][63:0] seen_init  = '0;

  task automatic check_b(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic check_s(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [4:0][63:0] rand_state();
    logic [4:0][63:0] r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  // Ascon init finalization: key XORed into the two low-order words of the permuted state.
  function automatic logic [4:0][63:0] model_rsp(input logic [127:0] k, input logic [4:0][63:0] c);
    logic [4:0][63:0] r;
    r    = c;
    r[3] = c[3] ^ k[127:64];
    r[4] = c[4] ^ k[63:0];
    return r;
  endfunction

  task automatic stray_engine();
    bus.init_update_i   = 1'($urandom_range(0, 1));
    bus.init_finished_i = 1'($urandom_range(0, 1));
    bus.init_state_i    = rand_state();
  endtask

  // One request: engine updates on RUN cycles 1..n_upd, finishes on RUN cycle fin_at
  // (0 = never), host holds the response for 'hold' cycles. Called and returns at an idle negedge.
  task automatic txn(input logic [127:0] k, input logic [127:0] n, input int n_upd,
                     input int fin_at, input int hold, input bit ones_last);
    int r, e;
    bit fin;
    logic [4:0][63:0] cap;
    fin = (fin_at != 0);
    r   = fin ? fin_at : TIMEOUT;
    bus.key_i       = k;
    bus.nonce_i     = n;
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = (hold == 0);
    t_key   = k;
    t_nonce = n;
    t_R     = r;
    t_fin   = fin;
    t_acc   = cyc + 1;
    t_end   = BIG;
    e       = t_acc + r + 1 + int'(fin) + hold;
    cap     = '0;
    @(negedge clk);
    bus.req_valid_i = 1'($urandom_range(0, 1));
    bus.key_i       = rand128();
    stray_engine();
    for (int i = 1; i <= r; i++) begin
      @(negedge clk);
      bus.init_update_i = (i <= n_upd);
      bus.init_state_i  = rand_state();
      if (ones_last && i == n_upd) bus.init_state_i = '1;
      if (i <= n_upd) cap = bus.init_state_i;
      bus.init_finished_i = fin && (i == r);
      bus.req_valid_i     = 1'($urandom_range(0, 1));
      bus.key_i           = rand128();
    end
    t_exp = model_rsp(k, cap);
    @(negedge clk);
    stray_engine();
    while (cyc < e) begin
      bus.req_valid_i = 1'($urandom_range(0, 1));
      bus.key_i       = rand128();
      stray_engine();
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    t_end = e + 1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    stray_engine();
    txn_no++;
    $display("txn %0d key=%h upd=%0d fin_at=%0d hold=%0d", txn_no, k, n_upd, fin_at, hold);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the transaction timeline
  initial begin
    bit act, exp_rv;
    int rel;
    logic [4:0][63:0] built;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act    = (cyc >= t_acc) && (cyc < t_end);
        rel    = cyc - t_acc;
        built  = {t_nonce[63:0], t_nonce[127:64], t_key[63:0], t_key[127:64], IV};
        exp_rv = act && (rel >= t_R + 1 + int'(t_fin));
        check_b("req_ready", bus.req_ready_o, !act);
        check_b("busy", bus.busy_o, act);
        check_b("init_start", bus.init_start_o, act && rel == 0);
        check_s("init_state", bus.init_state_o, (act && rel <= t_R) ? built : '0);
        check_b("rsp_valid", bus.rsp_valid_o, exp_rv);
        check_b("rsp_err", bus.rsp_err_o, exp_rv && !t_fin);
        if (exp_rv && t_fin) check_s("rsp_state", bus.rsp_state_o, t_exp);
        else if (!exp_rv) check_s("rsp_state_idle", bus.rsp_state_o, '0);
        if (bus.init_start_o) begin
          start_cnt++;
          seen_init = bus.init_state_o;
        end
        if (bus.rsp_valid_o && !prev_valid) begin
          rise_cnt++;
          last_rise = cyc;
          seen_rsp  = bus.rsp_state_o;
          seen_err  = bus.rsp_err_o;
        end
        prev_valid = bus.rsp_valid_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kn, nn, rk;
    int s0, r0, a0, n_upd, fin_at;
    kn = 128'h000102030405060708090a0b0c0d0e0f;
    nn = 128'h101112131415161718191a1b1c1d1e1f;
    bus.req_valid_i     = 1'b0;
    bus.key_i           = '0;
    bus.nonce_i         = '0;
    bus.init_state_i    = '0;
    bus.init_update_i   = 1'b0;
    bus.init_finished_i = 1'b0;
    bus.rsp_ready_i     = 1'b0;

    // Two reset edges
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check_b("reset_req_ready", bus.req_ready_o, 1'b1);
    check_b("reset_busy", bus.busy_o, 1'b0);
    check_b("reset_rsp_valid", bus.rsp_valid_o, 1'b0);
    check_b("reset_init_start", bus.init_start_o, 1'b0);
    check_s("reset_rsp_state", bus.rsp_state_o, '0);

    // Nominal: 12 round updates, all-ones on round 12, finish on the following cycle
    txn(kn, nn, 12, 13, 0, 1'b1);
    check_w("nom_init_x0", seen_init[0], 64'h80400c0600000000);
    check_w("nom_init_x1", seen_init[1], 64'h0001020304050607);
    check_i("nom_latency", last_rise - t_acc, 15);
    check_w("nom_x0", seen_rsp[0], 64'hffffffffffffffff);
    check_w("nom_x2", seen_rsp[2], 64'hffffffffffffffff);
    check_w("nom_x3", seen_rsp[3], ~64'h0001020304050607);
    check_w("nom_x4", seen_rsp[4], ~64'h08090a0b0c0d0e0f);
    check_b("nom_err", seen_err, 1'b0);

    // Backpressure: 10 cycles without rsp_ready while key/req_valid toggle
    s0 = start_cnt;
    txn(rand128(), rand128(), 12, 13, 10, 1'b0);
    check_i("bp_starts", start_cnt - s0, 1);

    // Timeout, then finish coinciding with the timeout cycle
    txn(rand128(), rand128(), 5, 0, 1, 1'b0);
    check_i("to_latency", last_rise - t_acc, 21);
    check_b("to_err", seen_err, 1'b1);
    txn(rand128(), rand128(), 12, TIMEOUT, 0, 1'b0);
    check_i("to_tie_latency", last_rise - t_acc, 22);
    check_b("to_tie_err", seen_err, 1'b0);

    // Reset during RUN after round 5, then a stray finish pulse
    r0 = rise_cnt;
    rk = rand128();
    bus.key_i       = rk;
    bus.nonce_i     = rand128();
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = 1'b0;
    t_key   = rk;
    t_nonce = bus.nonce_i;
    t_R     = 13;
    t_fin   = 1'b1;
    t_acc   = cyc + 1;
    t_end   = BIG;
    a0      = t_acc;
    @(negedge clk);
    bus.req_valid_i     = 1'b0;
    bus.init_update_i   = 1'b0;
    bus.init_finished_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.init_update_i = 1'b1;
      bus.init_state_i  = rand_state();
    end
    @(negedge clk);
    bus.init_update_i = 1'b0;
    rst   = 1'b1;
    t_end = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.init_finished_i = 1'b1;
    @(negedge clk);
    bus.init_finished_i = 1'b0;
    @(negedge clk);
    check_i("abort_no_rsp", rise_cnt - r0, 0);
    check_b("abort_idle", bus.req_ready_o, 1'b1);
    check_i("abort_cycles", cyc - a0, 10);
    txn_no++;
    $display("txn %0d key=%h aborted by reset after round 5", txn_no, rk);

    // New request after the abort completes normally
    txn(kn, nn, 12, 13, 0, 1'b1);
    check_i("post_abort_latency", last_rise - t_acc, 15);
    check_w("post_abort_x4", seen_rsp[4], ~64'h08090a0b0c0d0e0f);

    // Back-to-back with rsp_ready tied high
    s0 = start_cnt;
    r0 = rise_cnt;
    txn(rand128(), rand128(), 12, 13, 0, 1'b0);
    txn(rand128(), rand128(), 12, 13, 0, 1'b0);
    check_i("b2b_starts", start_cnt - s0, 2);
    check_i("b2b_rsps", rise_cnt - r0, 2);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      n_upd  = $urandom_range(1, 12);
      fin_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(n_upd, TIMEOUT);
      txn(rand128(), rand128(), n_upd, fin_at, $urandom_range(0, 3), 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
